// File: rtl/jamma_pkg.sv
// Shared JAMMA joystick bit map, released-state constant and elaboration helpers.
package jamma_pkg;

  localparam int unsigned JOY_UP    = 0;
  localparam int unsigned JOY_DOWN  = 1;
  localparam int unsigned JOY_LEFT  = 2;
  localparam int unsigned JOY_RIGHT = 3;
  localparam int unsigned JOY_FIRE1 = 4;
  localparam int unsigned JOY_FIRE2 = 5;
  localparam int unsigned JOY_SPARE = 6;
  localparam int unsigned JOY_START = 7;

  localparam logic [7:0] JOY_RELEASED = 8'hFF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One debounced joystick bit: the output follows the sample only after
// DEBOUNCE_SCANS consecutive disagreeing samples; DEBOUNCE_SCANS=0 bypasses.
module joy_debounce_bit
  import jamma_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter logic        RESET_VAL      = 1'b1
) (
  input  logic i_pclk,
  input  logic i_reset,
  input  logic i_sample_en,
  input  logic i_s,
  output logic o_q
);

  localparam int unsigned CNT_RAW = clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;

  logic r_q;

  if (DEBOUNCE_SCANS == 0) begin : g_bypass
    always_ff @(posedge i_pclk) begin
      if (i_reset) begin
        r_q <= RESET_VAL;
      end else if (i_sample_en) begin
        r_q <= i_s;
      end
    end
  end else begin : g_count
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Any sample agreeing with the output restarts the run of disagreements.
    always_ff @(posedge i_pclk) begin
      if (i_reset) begin
        r_q   <= RESET_VAL;
        r_cnt <= '0;
      end else if (i_sample_en) begin
        if (i_s == r_q) begin
          r_cnt <= '0;
        end else if (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
          r_q   <= i_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jamma_joy_scan.sv
// Time-multiplexed JAMMA joystick scanner: cycles the external select through
// every player slot, samples after a settle delay and debounces each bit.
module jamma_joy_scan
  import jamma_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned SEL_W          = 1
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic [7:0]               joy_bus,
  input  logic [5:0]               local_joy,
  input  logic                     merge_en,
  output logic [SEL_W-1:0]         select_out,
  output logic [8*NUM_PLAYERS-1:0] joy_out,
  output logic                     scan_done
);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_SAMPLE = 1'b1;

  logic [0:0]       r_state;
  logic [7:0]       r_cnt;
  logic [SEL_W-1:0] r_slot;
  logic             r_scan_done;

  logic             w_sample;
  logic             w_last_slot;
  logic [7:0]       w_s;

  assign w_sample    = (r_state == ST_SAMPLE);
  assign w_last_slot = (r_slot == SEL_W'(NUM_PLAYERS - 1));

  // The on-board joystick only ever merges into player 1's directions/fire.
  always_comb begin
    w_s = joy_bus;
    if ((r_slot == '0) && merge_en) begin
      w_s[JOY_FIRE2:JOY_UP] = joy_bus[JOY_FIRE2:JOY_UP] & local_joy;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state     <= ST_SETTLE;
      r_cnt       <= 8'd0;
      r_slot      <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        ST_SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(SETTLE_CYCLES - 1)) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_cnt       <= 8'd0;
          r_state     <= ST_SETTLE;
          r_slot      <= w_last_slot ? '0 : r_slot + 1'b1;
          r_scan_done <= w_last_slot;
        end
        default: r_state <= ST_SETTLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic w_sample_en;
    assign w_sample_en = w_sample && (r_slot == SEL_W'(p));

    for (genvar b = 0; b < 8; b++) begin : g_bit
      joy_debounce_bit #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .RESET_VAL     (JOY_RELEASED[b])
      ) u_bit (
        .i_pclk     (pclk),
        .i_reset    (reset),
        .i_sample_en(w_sample_en),
        .i_s        (w_s[b]),
        .o_q        (joy_out[8*p+b])
      );
    end
  end

  assign select_out = r_slot;
  assign scan_done  = r_scan_done;

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Directed bench for jamma_joy_scan: default 2-player instance plus a
// 3-player instance with a longer settle delay.
module tb_jamma_joy_scan;

  logic        pclk;
  logic        reset;
  logic [7:0]  joy_bus;
  logic [5:0]  local_joy;
  logic        merge_en;
  logic [0:0]  select_out;
  logic [15:0] joy_out;
  logic        scan_done;

  logic        reset3;
  logic [7:0]  bus3;
  logic [1:0]  select3;
  logic [23:0] joy3;
  logic        scan3;

  int vectors;
  int miscompares;
  int cyc;

  jamma_joy_scan #(
    .NUM_PLAYERS   (2),
    .SETTLE_CYCLES (2),
    .DEBOUNCE_SCANS(3),
    .SEL_W         (1)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .joy_bus   (joy_bus),
    .local_joy (local_joy),
    .merge_en  (merge_en),
    .select_out(select_out),
    .joy_out   (joy_out),
    .scan_done (scan_done)
  );

  jamma_joy_scan #(
    .NUM_PLAYERS   (3),
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(3),
    .SEL_W         (2)
  ) dut3 (
    .pclk      (pclk),
    .reset     (reset3),
    .joy_bus   (bus3),
    .local_joy (local_joy),
    .merge_en  (1'b0),
    .select_out(select3),
    .joy_out   (joy3),
    .scan_done (scan3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    joy_bus = 8'hFF;
    do_reset();
    vectors++;
    if (select_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_select: got %h expected 0", select_out);
    end
    vectors++;
    if (joy_out !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL reset_joy_out: got %h expected ffff", joy_out);
    end
    vectors++;
    if (scan_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_scan_done: got %b expected 0", scan_done);
    end
  endtask

  // Slot period 3 cycles; slot 0 sampled at 2, slot 1 at 5, scan_done at 6k.
  task automatic test_scan_timing();
    logic exp_sel;
    logic exp_done;
    joy_bus = 8'hFF;
    do_reset();
    while (cyc < 18) begin
      exp_sel  = ((cyc % 6) >= 3);
      exp_done = (cyc != 0) && ((cyc % 6) == 0);
      vectors++;
      if (select_out !== exp_sel) begin
        miscompares++;
        $display("FAIL scan_select c%0d: got %h expected %h", cyc, select_out, exp_sel);
      end
      vectors++;
      if (scan_done !== exp_done) begin
        miscompares++;
        $display("FAIL scan_done c%0d: got %b expected %b", cyc, scan_done, exp_done);
      end
      vectors++;
      if (joy_out !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL scan_joy_out c%0d: got %h expected ffff", cyc, joy_out);
      end
      step();
    end
  endtask

  task automatic test_fire1_slot1();
    do_reset();
    while (cyc <= 18) begin
      if (cyc == 17) begin
        vectors++;
        if (joy_out !== 16'hFFFF) begin
          miscompares++;
          $display("FAIL fire1_before: got %h expected ffff", joy_out);
        end
      end
      if (cyc == 18) begin
        vectors++;
        if (joy_out !== 16'hEFFF) begin
          miscompares++;
          $display("FAIL fire1_after: got %h expected efff", joy_out);
        end
      end
      joy_bus = ((cyc % 6) >= 3) ? 8'hEF : 8'hFF;
      step();
    end
  endtask

  task automatic test_glitch();
    do_reset();
    while (cyc <= 30) begin
      vectors++;
      if (joy_out[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL glitch_reject c%0d: got %b expected 1", cyc, joy_out[0]);
      end
      joy_bus = ((cyc % 6) == 2 && (cyc / 6) < 2) ? 8'hFE : 8'hFF;
      step();
    end
    do_reset();
    while (cyc <= 15) begin
      if (cyc == 14) begin
        vectors++;
        if (joy_out[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL glitch_accept_before: got %b expected 1", joy_out[0]);
        end
      end
      if (cyc == 15) begin
        vectors++;
        if (joy_out !== 16'hFFFE) begin
          miscompares++;
          $display("FAIL glitch_accept_after: got %h expected fffe", joy_out);
        end
      end
      joy_bus = ((cyc % 6) == 2 && (cyc / 6) < 3) ? 8'hFE : 8'hFF;
      step();
    end
    joy_bus = 8'hFF;
  endtask

  // Second phase keeps merge_en high except in slot 0's sample cycle.
  task automatic test_merge();
    joy_bus   = 8'hFF;
    merge_en  = 1'b1;
    local_joy = 6'b111110;
    do_reset();
    while (cyc <= 33) begin
      if (cyc == 14) begin
        vectors++;
        if (joy_out !== 16'hFFFF) begin
          miscompares++;
          $display("FAIL merge_before: got %h expected ffff", joy_out);
        end
      end
      if (cyc == 15 || cyc == 32) begin
        vectors++;
        if (joy_out !== 16'hFFFE) begin
          miscompares++;
          $display("FAIL merge_on c%0d: got %h expected fffe", cyc, joy_out);
        end
      end
      if (cyc == 33) begin
        vectors++;
        if (joy_out !== 16'hFFFF) begin
          miscompares++;
          $display("FAIL merge_off: got %h expected ffff", joy_out);
        end
      end
      merge_en = (cyc < 15) ? 1'b1 : ((cyc % 6) != 2);
      step();
    end
    merge_en  = 1'b0;
    local_joy = 6'h3F;
  endtask

  task automatic test_three_players();
    logic [1:0] exp_sel;
    logic       exp_done;
    bus3   = 8'hFF;
    reset3 = 1'b1;
    step();
    step();
    reset3 = 1'b0;
    cyc    = 0;
    while (cyc < 32) begin
      exp_sel  = 2'((cyc / 5) % 3);
      exp_done = (cyc != 0) && ((cyc % 15) == 0);
      vectors++;
      if (select3 !== exp_sel) begin
        miscompares++;
        $display("FAIL p3_select c%0d: got %h expected %h", cyc, select3, exp_sel);
      end
      vectors++;
      if (scan3 !== exp_done) begin
        miscompares++;
        $display("FAIL p3_scan_done c%0d: got %b expected %b", cyc, scan3, exp_done);
      end
      vectors++;
      if (joy3 !== 24'hFFFFFF) begin
        miscompares++;
        $display("FAIL p3_joy_out c%0d: got %h expected ffffff", cyc, joy3);
      end
      step();
    end
  endtask

  // Reset lands in slot 1's third sample, which would otherwise flip fire1.
  task automatic test_reset_mid_sample();
    do_reset();
    while (cyc < 17) begin
      joy_bus = ((cyc % 6) >= 3) ? 8'hEF : 8'hFF;
      step();
    end
    joy_bus = 8'hEF;
    reset   = 1'b1;
    step();
    vectors++;
    if (select_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_select: got %h expected 0", select_out);
    end
    vectors++;
    if (joy_out !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL midreset_joy_out: got %h expected ffff", joy_out);
    end
    vectors++;
    if (scan_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_scan_done: got %b expected 0", scan_done);
    end
    reset = 1'b0;
    cyc   = 0;
    while (cyc <= 18) begin
      if (cyc == 6 || cyc == 17) begin
        vectors++;
        if (joy_out !== 16'hFFFF) begin
          miscompares++;
          $display("FAIL midreset_restart c%0d: got %h expected ffff", cyc, joy_out);
        end
      end
      if (cyc == 18) begin
        vectors++;
        if (joy_out !== 16'hEFFF) begin
          miscompares++;
          $display("FAIL midreset_recount: got %h expected efff", joy_out);
        end
      end
      joy_bus = ((cyc % 6) >= 3) ? 8'hEF : 8'hFF;
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    reset3      = 1'b1;
    joy_bus     = 8'hFF;
    bus3        = 8'hFF;
    local_joy   = 6'h3F;
    merge_en    = 1'b0;

    test_reset();
    test_scan_timing();
    test_fire1_slot1();
    test_glitch();
    test_merge();
    test_three_players();
    test_reset_mid_sample();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jamma_joy_scan.md
Name: jamma_joy_scan

Overview:
- Parametrised successor to the two-player JAMMA joystick splitter.
- Time-multiplexes the shared 8-bit JAMMA joystick bus across NUM_PLAYERS select slots, with a programmable settle delay before each sample.
- Debounces every button bit and optionally merges the on-board DB9 joystick into player 1.
- Sits in each arcade top level between the JAMMA pins and the core's I_JOYSTICK_x / I_PLAYER inputs.

Parameters:
- NUM_PLAYERS, 2, number of multiplexed joystick slots (2..4).
- SETTLE_CYCLES, 2, pclk cycles between a select change and the sample (1..255).
- DEBOUNCE_SCANS, 3, consecutive identical samples required before an output bit changes; 0 = bypass.
- SEL_W, 1, width of select_out; must equal max(1, ceil(log2(NUM_PLAYERS))).

Ports:
- pclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- joy_bus  in  8  raw JAMMA joystick bus, active-low: [3:0] directions, [5:4] fire, [7] start, [6] spare.
- local_joy  in  6  on-board joystick, active-low.
- merge_en  in  1  1 = AND local_joy into player 0 bits [5:0].
- select_out  out  SEL_W  slot select driven to the external multiplexer (the JSELECT pin when SEL_W=1).
- joy_out  out  8*NUM_PLAYERS  debounced active-low state; player p occupies [8p+7:8p].
- scan_done  out  1  one-cycle pulse after the last slot of each full scan has been sampled.

Behaviour:
- Reset values: select_out=0, joy_out all 1s (all released), scan_done=0, FSM=SETTLE, settle counter=0, all debounce counters=0.
- FSM states: SETTLE and SAMPLE.
  - SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE (exactly one cycle):
    - Capture s = joy_bus. If slot==0 and merge_en=1, s[5:0] = s[5:0] & local_joy.
    - Feed s to the debouncer for the current slot.
    - Advance slot: slot = (slot==NUM_PLAYERS-1) ? 0 : slot+1, and drive it on select_out in the same cycle.
    - Clear the counter and return to SETTLE.
  - select_out changes only on SAMPLE->SETTLE, so the bus sees a stable select for SETTLE_CYCLES+1 cycles.
- Scan period is NUM_PLAYERS*(SETTLE_CYCLES+1) cycles.
- scan_done is asserted in the cycle after the SAMPLE of slot NUM_PLAYERS-1, for exactly one cycle.
- Debounce, per bit per player:
  - Counter width ceil(log2(DEBOUNCE_SCANS+1)).
  - On that player's sample: if s[b]==joy_out[b], the counter clears.
  - Otherwise the counter increments. When the incremented value reaches DEBOUNCE_SCANS, joy_out[b] takes s[b] and the counter clears.
  - joy_out updates one cycle after SAMPLE (registered).
  - DEBOUNCE_SCANS=0: joy_out[b] takes s[b] directly on each sample.
- Debounce latency: a clean change on slot p appears on joy_out after DEBOUNCE_SCANS samples of p, i.e. (DEBOUNCE_SCANS-1) full scan periods plus up to one scan period of phase.
- Glitch rule: any sample equal to the current output clears the counter; a glitch shorter than DEBOUNCE_SCANS consecutive samples never reaches joy_out.
- merge_en is sampled only in the SAMPLE cycle of slot 0. Toggling it elsewhere has no effect until that slot's next sample.
- Slots >= NUM_PLAYERS never occur. The slot counter wraps at NUM_PLAYERS-1, including non-power-of-2 counts (e.g. 3 -> 0,1,2,0).
- Reset asserted mid-scan, including during SAMPLE: next cycle all registers hold their reset values; the in-flight sample is discarded.
- SETTLE_CYCLES=1: SETTLE lasts one cycle, giving a scan period of 2*NUM_PLAYERS cycles.

Decomposition:
- Shared package jamma_pkg:
  - bit-index constants JOY_UP/DOWN/LEFT/RIGHT=0..3, JOY_FIRE1=4, JOY_FIRE2=5, JOY_SPARE=6, JOY_START=7.
  - JOY_RELEASED=8'hFF.
  - clog2 helper function.
- One sub-module, joy_debounce_bit: one bit's counter and output register, with inputs sample_en, s, and parameter DEBOUNCE_SCANS. Instantiated 8*NUM_PLAYERS times via generate.

Test Plan:
- Reset release, joy_bus=8'hFF, defaults -> select_out toggles 0,1 with period 3 cycles; scan_done pulses every 6 cycles; joy_out=16'hFFFF throughout.
- Slot 1 drives 8'hEF (fire1) steadily, DEBOUNCE_SCANS=3 -> joy_out[15:8]=8'hEF after the 3rd slot-1 sample; joy_out[7:0] stays 8'hFF.
- Slot 0 bit0 low for 2 samples, then high -> joy_out[0] stays 1 (glitch rejected). Low for 3 samples -> joy_out[0]=0.
- merge_en=1, local_joy=6'b111110, joy_bus=8'hFF on all slots -> joy_out[7:0]=8'hFE and joy_out[15:8]=8'hFF. With merge_en=0 -> returns to 8'hFF after 3 scans.
- NUM_PLAYERS=3, SEL_W=2, SETTLE_CYCLES=4 -> select_out sequence 0,1,2,0 with each value held 5 cycles; scan_done every 15 cycles.
- Assert reset in the SAMPLE cycle of slot 1 while counters are mid-count -> next cycle select_out=0, joy_out all 1s, scan_done=0; the debounce count restarts from 0.
